// File: rtl/modulo_timer_arbiter.sv
// Round-robin arbiter granting a shared modulo counter to one requester per period; done pulses when the owner's period ends.
// Grant latency: one cycle from IDLE; period is Mq cycles; optional abort on request drop via MODULO_TIMER_ARBITER_ABORT_EN.
module modulo_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] modulo,
    output logic [NREQ-1:0]    grant,
    output logic [CW-1:0]      count,
    output logic               busy,
    output logic [NREQ-1:0]    done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_mq;
    logic              r_busy;
    logic [IW-1:0]     r_last;

    logic [IW-1:0]     w_win;
    logic [IW-1:0]     w_cand;
    logic              w_any;
    logic [CW-1:0]     w_mod;

    // Search starts one past the last winner, so the most recent owner gets lowest priority.
    always_comb begin
        w_win  = '0;
        w_cand = '0;
        w_any  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(r_last) + k) % NREQ);
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_mod = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == IW'(i)) w_mod = modulo[i*CW +: CW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_mq    <= CW'(1);
            r_busy  <= 1'b0;
            r_last  <= IW'(NREQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done  <= '0;
                    r_count <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    if (w_any) begin
                        r_state <= S_RUN;
                        r_grant <= NREQ'(1) << w_win;
                        r_mq    <= (w_mod == '0) ? CW'(1) : w_mod;
                        r_last  <= w_win;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
`ifdef MODULO_TIMER_ARBITER_ABORT_EN
                    if ((req & r_grant) == '0) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else
`endif
                    if (r_count == r_mq - CW'(1)) begin
                        r_state <= S_DONE;
                        r_count <= '0;
                        r_grant <= '0;
                        r_done  <= r_grant;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant = r_grant;
    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

// File: tb/tb_modulo_timer_arbiter.sv
// Randomized scoreboard bench: stimulus predicts each grant (winner, period) from round-robin rules; a negedge monitor checks every period cycle by cycle.
module tb_modulo_timer_arbiter;
    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] modulo;
    logic [NREQ-1:0]    grant;
    logic [CW-1:0]      count;
    logic               busy;
    logic [NREQ-1:0]    done;

    modulo_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .modulo(modulo),
        .grant(grant), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int w; int m; } exp_t;
    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;
    int   m_last = NREQ - 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int rr(input int last, input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int w);
        logic [NREQ-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Monitor: pops an expectation at each new grant and walks the period.
    int cur_w, cur_m, c, gap;
    bit in_ep = 0, exp_done = 0, had_done = 0;
    always @(negedge clk) begin
        if (!rst) begin
            in_ep = 0; exp_done = 0; had_done = 0;
            chk("reset_grant", grant, 0);
        end else if (exp_done) begin
            chk("done_pulse", done, onehot(cur_w));
            chk("done_grant", grant, 0);
            chk("done_count", count, 0);
            chk("done_busy", busy, 1);
            exp_done = 0; had_done = 1; gap = 0;
        end else begin
            chk("done_quiet", done, 0);
            if (had_done) gap++;
            if (!in_ep) begin
                if (grant != 0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_grant", grant, 0);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        cur_w = e.w; cur_m = e.m; c = 0; in_ep = 1;
                        if (had_done) chk("regrant_gap", gap, 2);
                        had_done = 0;
                    end
                end else begin
                    chk("idle_busy", busy, 0);
                    chk("idle_count", count, 0);
                end
            end
            if (in_ep) begin
                chk("run_grant", grant, onehot(cur_w));
                chk("run_count", count, c);
                chk("run_busy", busy, 1);
                if (c == cur_m - 1) begin
                    in_ep = 0; exp_done = 1;
                end
                c++;
            end
        end
    end

    task automatic setup(input logic [NREQ-1:0] mask, input logic [NREQ*CW-1:0] mv);
        exp_t e;
        int w;
        req = mask;
        modulo = mv;
        w = rr(m_last, mask);
        e.w = w;
        e.m = (mv[w*CW +: CW] == 0) ? 1 : int'(mv[w*CW +: CW]);
        sbq.push_back(e);
        m_last = w;
    endtask

    task automatic wait_grant();
        bit ok = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (grant != 0) begin ok = 1; break; end
        end
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    // Scrambles modulo every run cycle: the latched period must not move.
    task automatic run_txn(input int drop_at);
        bit ok = 0;
        wait_grant();
        for (int k = 0; k < 300; k++) begin
            if (done != 0) begin ok = 1; break; end
            if (drop_at >= 0 && int'(count) == drop_at) req = req & ~grant;
            modulo = $urandom;
            @(posedge clk); #2;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    function automatic logic [NREQ*CW-1:0] pack(input int a, input int b, input int c2, input int d);
        return {CW'(d), CW'(c2), CW'(b), CW'(a)};
    endfunction

    initial begin
        rst = 1'b0;
        req = '0;
        modulo = '0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        for (int n = 0; n < 5; n++) begin
            setup(4'b1111, pack(3, 3, 3, 3));
            run_txn(-1);
        end
        setup(4'b0001, pack(6, 1, 1, 1));   run_txn(-1);
        setup(4'b0001, pack(0, 9, 9, 9));   run_txn(-1);
        setup(4'b0001, pack(1, 9, 9, 9));   run_txn(-1);
        setup(4'b0001, pack(255, 2, 2, 2)); run_txn(-1);
        setup(4'b0010, pack(2, 10, 2, 2));  run_txn(4);

        for (int n = 0; n < 40; n++) begin
            setup(NREQ'($urandom_range(1, 15)),
                  pack($urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 7), $urandom_range(0, 7)));
            run_txn(-1);
        end

        setup(4'b0001, pack(8, 2, 2, 2));
        wait_grant();
        for (int k = 0; k < 20; k++) begin
            if (count == 3) break;
            @(posedge clk); #2;
        end
        chk("pre_reset_count", count, 3);
        rst = 1'b0;
        #1;
        chk("async_grant", grant, 0);
        chk("async_count", count, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        repeat (2) @(posedge clk);
        #2;
        m_last = NREQ - 1;
        setup(4'b1010, pack(4, 5, 4, 6));
        rst = 1'b1;
        run_txn(-1);

        req = '0;
        repeat (4) @(posedge clk);
        #2;
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
